// File: rtl/util_delay_skid.sv
// util_delay_skid: two-entry skid buffer with registered in_ready, flush and saturating drop counter
module util_delay_skid #(
  parameter int WIDTH = 32,
  parameter logic [WIDTH-1:0] RESET_DATA = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] in_data,
  output logic             in_ready,
  output logic             out_valid,
  output logic [WIDTH-1:0] out_data,
  input  logic             out_ready,
  input  logic             flush,
  output logic [1:0]       occupancy,
  output logic [15:0]      drop_count
);
  localparam logic [1:0] EMPTY = 2'd0, ONE = 2'd1, FULL = 2'd2;
  logic [1:0]       state_q, state_d;
  logic [WIDTH-1:0] main_q, main_d, skid_q, skid_d;
  logic             in_ready_q, in_ready_d;
  logic [15:0]      drop_q, drop_d;
  logic [1:0]       drop_inc;
  logic [16:0]      drop_sum;
  logic             accept, emit;
  assign accept = in_valid & in_ready_q;
  assign emit   = (state_q != EMPTY) & out_ready;
  // state, data and counter registers; reset leaves in_ready low until the first edge
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= EMPTY;
      main_q     <= RESET_DATA;
      skid_q     <= RESET_DATA;
      in_ready_q <= 1'b0;
      drop_q     <= '0;
    end else begin
      state_q    <= state_d;
      main_q     <= main_d;
      skid_q     <= skid_d;
      in_ready_q <= in_ready_d;
      drop_q     <= drop_d;
    end
  end
  // next state and data movement; flush overrides any accept or emit
  always_comb begin
    state_d = state_q;
    main_d  = main_q;
    skid_d  = skid_q;
    if (flush) begin
      state_d = EMPTY;
      main_d  = RESET_DATA;
      skid_d  = RESET_DATA;
    end else begin
      case (state_q)
        EMPTY: begin
          state_d = accept ? ONE : EMPTY;
          main_d  = accept ? in_data : main_q;
        end
        ONE: begin
          state_d = (accept & ~emit) ? FULL : (emit & ~accept) ? EMPTY : ONE;
          skid_d  = (accept & ~emit) ? in_data : skid_q;
          main_d  = (accept & emit) ? in_data : main_q;
        end
        FULL: begin
          state_d = emit ? ONE : FULL;
          main_d  = emit ? skid_q : main_q;
        end
        default: state_d = EMPTY;
      endcase
    end
    in_ready_d = state_d != FULL;
  end
  // words lost to a flush: everything held except a word delivered in the same cycle
  always_comb begin
    drop_inc = state_q - {1'b0, emit};
    drop_sum = {1'b0, drop_q} + {15'd0, drop_inc};
    drop_d   = flush ? (drop_sum[16] ? 16'hFFFF : drop_sum[15:0]) : drop_q;
  end
  // outputs come straight from registered state
  always_comb begin
    out_valid  = state_q != EMPTY;
    occupancy  = state_q;
    in_ready   = in_ready_q;
    out_data   = main_q;
    drop_count = drop_q;
  end
endmodule
